// File: rtl/decode_issue.sv
// Decode/issue stage: one-entry decode latch, 16x16 register file, per-register pending scoreboard.
// Latency: an instruction accepted at edge N drives the D outputs during cycle N+1.
// Backpressure: inst_ready drops while the held instruction is blocked by a RAW/WAW hazard.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   inst_valid/ready    fetch handshake; instF = {RW, MW, alufunc[1:0], src1, src2, dest}, pcF
//   wb_en/addr/data     writeback from the end of the pipeline (write-through to operand reads)
//   *D outputs          values sampled by the execute pipeline register; RegWriteD/MemWriteD are 0 on a bubble
//   stall, stall_cnt    hazard indication and saturating stall-cycle counter
// Build option: define ZERO_REG_EN to make register 0 a hard-wired zero.
module decode_issue #(
  parameter int DW   = 16,
  parameter int NREG = 16,
  parameter int PCW  = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           inst_valid,
  output logic           inst_ready,
  input  logic [15:0]    instF,
  input  logic [PCW-1:0] pcF,
  input  logic           wb_en,
  input  logic [3:0]     wb_addr,
  input  logic [DW-1:0]  wb_data,
  output logic           RegWriteD,
  output logic           MemWriteD,
  output logic [1:0]     alufuncD,
  output logic [DW-1:0]  srcdataD1,
  output logic [DW-1:0]  srcdataD2,
  output logic [3:0]     destaddD,
  output logic [PCW-1:0] pcD,
  output logic           stall,
  output logic [15:0]    stall_cnt
);

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic [1:0] alufunc;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;
  } inst_t;

  logic            held_valid;
  inst_t           held;
  logic [PCW-1:0]  held_pc;
  logic [DW-1:0]   regfile [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_next;

  logic wb_eff;
  logic clr1, clr2, clrd;
  logic dest_trackable;
  logic hazard, issue, accept;

`ifdef ZERO_REG_EN
  // Register 0 is never written, never pending and never forwarded, so it
  // always reads as its reset value of zero.
  assign wb_eff         = wb_en && (wb_addr != 4'd0);
  assign dest_trackable = (held.dest != 4'd0);
`else
  assign wb_eff         = wb_en;
  assign dest_trackable = 1'b1;
`endif

  // A writeback in this cycle both releases the pending bit and supplies the operand.
  assign clr1 = wb_eff && (wb_addr == held.src1);
  assign clr2 = wb_eff && (wb_addr == held.src2);
  assign clrd = wb_eff && (wb_addr == held.dest);

  assign hazard = held_valid &&
                  ((pend[held.src1] && !clr1) ||
                   (pend[held.src2] && !clr2) ||
                   (held.rw && pend[held.dest] && !clrd));
  assign issue      = held_valid && !hazard;
  assign inst_ready = !held_valid || issue;
  assign accept     = inst_valid && inst_ready;
  assign stall      = hazard;

  // D-side outputs. Only the control bits are gated on a bubble; the rest
  // follow the latch and are ignored downstream.
  assign RegWriteD = issue && held.rw;
  assign MemWriteD = issue && held.mw;
  assign alufuncD  = held.alufunc;
  assign destaddD  = held.dest;
  assign pcD       = held_pc;
  assign srcdataD1 = clr1 ? wb_data : regfile[held.src1];
  assign srcdataD2 = clr2 ? wb_data : regfile[held.src2];

  // Set after clear so an issuing writer re-arms a register whose previous
  // producer is retiring in the same cycle.
  always_comb begin
    pend_next = pend;
    if (wb_eff) begin
      pend_next[wb_addr] = 1'b0;
    end
    if (issue && held.rw && dest_trackable) begin
      pend_next[held.dest] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_valid <= 1'b0;
      held       <= '0;
      held_pc    <= '0;
      pend       <= '0;
      stall_cnt  <= '0;
      for (int i = 0; i < NREG; i++) begin
        regfile[i] <= '0;
      end
    end else begin
      if (accept) begin
        held       <= instF;
        held_pc    <= pcF;
        held_valid <= 1'b1;
      end else if (issue) begin
        held_valid <= 1'b0;
      end
      pend <= pend_next;
      if (wb_eff) begin
        regfile[wb_addr] <= wb_data;
      end
      if (hazard && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed stimulus pushes expected issue records into a
// queue; a negedge monitor pops them whenever RegWriteD/MemWriteD is seen and also
// checks per-cycle ready/stall/stall_cnt expectations set by the stimulus.
module tb_decode_issue;

`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] instF;
  logic [11:0] pcF;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        RegWriteD;
  logic        MemWriteD;
  logic [1:0]  alufuncD;
  logic [15:0] srcdataD1;
  logic [15:0] srcdataD2;
  logic [3:0]  destaddD;
  logic [11:0] pcD;
  logic        stall;
  logic [15:0] stall_cnt;

  decode_issue #(.DW(16), .NREG(16), .PCW(12)) dut (
    .clk(clk), .reset(reset),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instF(instF), .pcF(pcF),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .alufuncD(alufuncD),
    .srcdataD1(srcdataD1), .srcdataD2(srcdataD2), .destaddD(destaddD),
    .pcD(pcD), .stall(stall), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic [1:0] af;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [3:0] dest;
    logic [11:0] pc;
  } rec_t;

  rec_t        q[$];
  bit          chk_en = 1'b0;
  bit          rst_chk = 1'b0;
  bit          done = 1'b0;
  logic        exp_ready = 1'b1;
  logic        exp_stall = 1'b0;
  logic [15:0] exp_cnt = '0;
  logic [15:0] model_cnt = '0;
  int          errors = 0;
  int          checks = 0;
  int          cycles = 0;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    rec_t e;
    rec_t g;
    cycles++;
    if (cycles > 90000) begin
      checks++;
      errors++;
      $display("FAIL timeout: cycles=%0d, required finish before 90000", cycles);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
    if (RegWriteD || MemWriteD) begin
      g.rw = RegWriteD; g.mw = MemWriteD; g.af = alufuncD;
      g.d1 = srcdataD1; g.d2 = srcdataD2; g.dest = destaddD; g.pc = pcD;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got rw=%0b mw=%0b pc=%h, required no issue", g.rw, g.mw, g.pc);
      end else begin
        e = q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL issue: got rw=%0b mw=%0b af=%0d d1=%h d2=%h dest=%0d pc=%h, required rw=%0b mw=%0b af=%0d d1=%h d2=%h dest=%0d pc=%h",
                   g.rw, g.mw, g.af, g.d1, g.d2, g.dest, g.pc, e.rw, e.mw, e.af, e.d1, e.d2, e.dest, e.pc);
        end
      end
    end
    if (chk_en) begin
      checks++;
      if (inst_ready !== exp_ready) begin
        errors++;
        $display("FAIL inst_ready @%0d: got %b, required %b", cycles, inst_ready, exp_ready);
      end
      checks++;
      if (stall !== exp_stall) begin
        errors++;
        $display("FAIL stall @%0d: got %b, required %b", cycles, stall, exp_stall);
      end
      checks++;
      if (stall_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL stall_cnt @%0d: got %h, required %h", cycles, stall_cnt, exp_cnt);
      end
    end
    if (rst_chk) begin
      checks++;
      if ({RegWriteD, MemWriteD, alufuncD, srcdataD1, srcdataD2, destaddD, pcD} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got rw=%b mw=%b af=%0d d1=%h d2=%h dest=%0d pc=%h, required all 0",
                 RegWriteD, MemWriteD, alufuncD, srcdataD1, srcdataD2, destaddD, pcD);
      end
    end
    if (done) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL missing_issues: got %0d expected issues never seen, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic iv, input logic [15:0] ins, input logic [11:0] pc,
                      input logic we, input logic [3:0] wa, input logic [15:0] wd,
                      input logic erdy, input logic estl);
    inst_valid = iv; instF = ins; pcF = pc;
    wb_en = we; wb_addr = wa; wb_data = wd;
    exp_ready = erdy; exp_stall = estl; exp_cnt = model_cnt; chk_en = 1'b1;
    @(posedge clk); #1;
    if (estl && (model_cnt != 16'hFFFF)) model_cnt = model_cnt + 16'd1;
    rst_chk = 1'b0;
  endtask

  task automatic idle(input logic erdy, input logic estl);
    step(1'b0, 16'h0, 12'h0, 1'b0, 4'd0, 16'h0, erdy, estl);
  endtask

  task automatic wb(input logic [3:0] wa, input logic [15:0] wd, input logic erdy, input logic estl);
    step(1'b0, 16'h0, 12'h0, 1'b1, wa, wd, erdy, estl);
  endtask

  task automatic send(input logic [15:0] ins, input logic [11:0] pc, input logic erdy, input logic estl);
    step(1'b1, ins, pc, 1'b0, 4'd0, 16'h0, erdy, estl);
  endtask

  task automatic expect_issue(input logic rw, input logic mw, input logic [1:0] af,
                              input logic [15:0] d1, input logic [15:0] d2,
                              input logic [3:0] dst, input logic [11:0] pc);
    rec_t r;
    r.rw = rw; r.mw = mw; r.af = af; r.d1 = d1; r.d2 = d2; r.dest = dst; r.pc = pc;
    q.push_back(r);
  endtask

  initial begin
    reset = 1'b0; inst_valid = 1'b0; instF = '0; pcF = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    @(posedge clk); #1;
    rst_chk = 1'b1; idle(1'b1, 1'b0);
    reset = 1'b1;
    rst_chk = 1'b1; idle(1'b1, 1'b0);

    // Basic issue with operands from the register file
    wb(4'd3, 16'h1234, 1'b1, 1'b0);
    wb(4'd4, 16'h0F0F, 1'b1, 1'b0);
    send(16'h8345, 12'h010, 1'b1, 1'b0);
    expect_issue(1'b1, 1'b0, 2'd0, 16'h1234, 16'h0F0F, 4'd5, 12'h010);
    // Back-to-back RAW on r5: no bubble at accept, then stall until writeback
    send(16'h9506, 12'h011, 1'b1, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    expect_issue(1'b1, 1'b0, 2'd1, 16'hAAAA, 16'h0000, 4'd6, 12'h011);
    wb(4'd5, 16'hAAAA, 1'b1, 1'b0);
    wb(4'd6, 16'h5555, 1'b1, 1'b0);

    // WAW on r7, then set-wins-over-clear keeps r7 pending
    send(16'h8127, 12'h020, 1'b1, 1'b0);
    expect_issue(1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 4'd7, 12'h020);
    send(16'hA347, 12'h021, 1'b1, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    expect_issue(1'b1, 1'b0, 2'd2, 16'h1234, 16'h0F0F, 4'd7, 12'h021);
    wb(4'd7, 16'h7777, 1'b1, 1'b0);
    send(16'hC708, 12'h030, 1'b1, 1'b0);
    idle(1'b0, 1'b1);
    expect_issue(1'b1, 1'b1, 2'd0, 16'h8888, 16'h0000, 4'd8, 12'h030);
    wb(4'd7, 16'h8888, 1'b1, 1'b0);
    wb(4'd8, 16'h0000, 1'b1, 1'b0);

    // Register 0 behaviour
    wb(4'd0, 16'hBEEF, 1'b1, 1'b0);
    send(16'h8001, 12'h040, 1'b1, 1'b0);
    expect_issue(1'b1, 1'b0, 2'd0, ZR ? 16'h0000 : 16'hBEEF, ZR ? 16'h0000 : 16'hBEEF, 4'd1, 12'h040);
    idle(1'b1, 1'b0);
    step(1'b1, 16'h8000, 12'h050, 1'b1, 4'd1, 16'h0000, 1'b1, 1'b0);
    expect_issue(1'b1, 1'b0, 2'd0, ZR ? 16'h0000 : 16'hBEEF, ZR ? 16'h0000 : 16'hBEEF, 4'd0, 12'h050);
    send(16'h8001, 12'h051, 1'b1, 1'b0);
`ifdef ZERO_REG_EN
    expect_issue(1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 4'd1, 12'h051);
    idle(1'b1, 1'b0);
    wb(4'd1, 16'h0000, 1'b1, 1'b0);
`else
    idle(1'b0, 1'b1);
    expect_issue(1'b1, 1'b0, 2'd0, 16'h1111, 16'h1111, 4'd1, 12'h051);
    wb(4'd0, 16'h1111, 1'b1, 1'b0);
    wb(4'd1, 16'h0000, 1'b1, 1'b0);
`endif

    // Long stall on r9 to saturate stall_cnt
    send(16'h8129, 12'h060, 1'b1, 1'b0);
    expect_issue(1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 4'd9, 12'h060);
    send(16'h8900, 12'h061, 1'b1, 1'b0);
    for (int i = 0; i < 65536; i++) begin
      idle(1'b0, 1'b1);
    end
    idle(1'b0, 1'b1);

    // Asynchronous reset mid-stall discards the held instruction and pending bits
    reset = 1'b0;
    model_cnt = '0;
    rst_chk = 1'b1; idle(1'b1, 1'b0);
    reset = 1'b1;
    rst_chk = 1'b1; idle(1'b1, 1'b0);
    wb(4'd9, 16'h9999, 1'b1, 1'b0);
    send(16'h8900, 12'h070, 1'b1, 1'b0);
    expect_issue(1'b1, 1'b0, 2'd0, 16'h9999, 16'h0000, 4'd0, 12'h070);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    done = 1'b1;
  end

endmodule
